mux_sel_sequencer: RTL

//  Upstream control stage for the combinational 4:1 mux (selects s0/s1, data return y).

---
 rtl/mux_sel_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Purpose:
//   Control stage in front of a combinational 4:1 mux. On an accepted start it
//   walks the mux select {s0,s1} through the channels enabled in ch_mask, from
//   the lowest index to the highest. Each channel is held for DWELL cycles. The
//   mux output y is captured on the last cycle of each hold. When the sweep
//   ends, the captured 4-bit vector is presented with a one-cycle done pulse.
//
// Parameters:
//   DWELL  cycles per channel, legal range 2..255; y is captured on dwell
//          cycle DWELL-1
//   CNT_W  dwell counter width, must satisfy 2**CNT_W > DWELL
//
// Ports:
//   i_clk           in   1  clock, rising edge
//   i_rst           in   1  synchronous active-high reset
//   i_start         in   1  sweep request, only honoured in IDLE
//   i_ch_mask       in   4  channel enables, latched on an accepted start
//   i_y             in   1  mux output return path
//   o_s0            out  1  mux select MSB (channel index = {s0,s1})
//   o_s1            out  1  mux select LSB
//   o_busy          out  1  high from the cycle after accept through DONE
//   o_done          out  1  one-cycle sweep-complete pulse
//   o_sample        out  4  captured vector, 0 for disabled channels
//   o_sample_valid  out  1  one-cycle pulse, coincident with o_done
//
// Configuration macro:
//   AUTO_RESTART_EN  when defined, DONE with start=1 and a non-zero mask goes
//                    straight into a new sweep, keeping busy high.
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_ch_mask,
  input  logic       i_y,
  output logic       o_s0,
  output logic       o_s1,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_sample,
  output logic       o_sample_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(0);

  // Lowest enabled channel with index >= from. Bit 2 of the result is set
  // when no such channel exists.
  function automatic logic [2:0] f_find_ch(input logic [3:0] mask,
                                           input logic [2:0] from);
    logic [2:0] res;
    if ((from == 3'd0) && mask[0]) begin
      res = 3'd0;
    end else if ((from <= 3'd1) && mask[1]) begin
      res = 3'd1;
    end else if ((from <= 3'd2) && mask[2]) begin
      res = 3'd2;
    end else if ((from <= 3'd3) && mask[3]) begin
      res = 3'd3;
    end else begin
      res = 3'd4;
    end
    return res;
  endfunction

  state_t           r_state;
  logic [3:0]       r_mask;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_shadow;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_sample;
  logic             r_sample_valid;

  state_t           w_state_nxt;
  logic [3:0]       w_mask_nxt;
  logic [1:0]       w_sel_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_shadow_nxt;
  logic [2:0]       w_first;
  logic [2:0]       w_after;

  // First channel of a new sweep comes from the live mask; the next channel
  // within a sweep comes from the latched copy.
  assign w_first = f_find_ch(i_ch_mask, 3'd0);
  assign w_after = f_find_ch(r_mask, {1'b0, r_sel} + 3'd1);

  // Next-state and next-datapath logic. The select register itself is the
  // channel index, parked at 0 outside SCAN.
  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_mask_nxt   = i_ch_mask;
          w_cnt_nxt    = LP_CNT_ZERO;
          w_shadow_nxt = 4'd0;
          if (!w_first[2]) begin
            w_state_nxt = ST_SCAN;
            w_sel_nxt   = w_first[1:0];
          end else begin
            w_state_nxt = ST_DONE;
            w_sel_nxt   = 2'd0;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (r_cnt == LP_CNT_LAST) begin
          // Last dwell cycle: the mux has settled for DWELL-1 cycles.
          w_shadow_nxt[r_sel] = i_y;
          w_cnt_nxt           = LP_CNT_ZERO;
          if (!w_after[2]) begin
            w_sel_nxt = w_after[1:0];
          end else begin
            w_state_nxt = ST_DONE;
            w_sel_nxt   = 2'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      ST_DONE: begin
`ifdef AUTO_RESTART_EN
        if (i_start && !w_first[2]) begin
          w_state_nxt  = ST_SCAN;
          w_mask_nxt   = i_ch_mask;
          w_sel_nxt    = w_first[1:0];
          w_cnt_nxt    = LP_CNT_ZERO;
          w_shadow_nxt = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = 2'd0;
        end
`else
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 2'd0;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 2'd0;
      end
    endcase
  end

  // State and datapath registers; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_mask         <= 4'd0;
      r_sel          <= 2'd0;
      r_cnt          <= LP_CNT_ZERO;
      r_shadow       <= 4'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sample       <= 4'd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mask         <= w_mask_nxt;
      r_sel          <= w_sel_nxt;
      r_cnt          <= w_cnt_nxt;
      r_shadow       <= w_shadow_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_done         <= (w_state_nxt == ST_DONE);
      r_sample_valid <= (w_state_nxt == ST_DONE);
      // The final capture lands on the same edge as entry to DONE, so take
      // the next shadow value rather than the registered one.
      if (w_state_nxt == ST_DONE) begin
        r_sample <= w_shadow_nxt;
      end else begin
        r_sample <= r_sample;
      end
    end
  end

  assign o_s0           = r_sel[1];
  assign o_s1           = r_sel[0];
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;

endmodule
